// File: rtl/motor_drive_decoder.sv
// motor_drive_decoder: filters DIR, updates PWM duty and H-bridge polarity at period boundaries, and inserts dead-time before reversals
//  clk, rst (async, active-high); DIR {side,level}, Direction (1 = forwards)
//  L_PWM/R_PWM bridge enables; L_IN/R_IN bridge inputs (10 fwd, 01 rev, 11 brake, 00 coast)
//  CMD code driving the motors; DEAD high during dead-time
module motor_drive_decoder #(
  parameter int PWM_PERIOD = 1000,
  parameter int CNT_W      = 10,
  parameter int DUTY_FULL  = 900,
  parameter int DUTY_VEER  = 600,
  parameter int DUTY_HARD  = 300,
  parameter int DUTY_PIVOT = 700,
  parameter int CMD_HOLD   = 16,
  parameter int DEADTIME   = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] DIR,
  input  logic       Direction,
  output logic       L_PWM,
  output logic       R_PWM,
  output logic [1:0] L_IN,
  output logic [1:0] R_IN,
  output logic [3:0] CMD,
  output logic       DEAD
);
  localparam int HW = $clog2(CMD_HOLD + 1);
  localparam int DW = $clog2(DEADTIME + 1);
  typedef enum logic [1:0] {RUN, DEADT, WAIT_WRAP} state_t;
  state_t state;
  logic [4:0] samp, pend;
  logic [HW-1:0] hcnt;
  logic [DW-1:0] dcnt;
  logic [CNT_W-1:0] cnt, cnt_n, l_duty, r_duty, ld_n, rd_n, nl_duty, nr_duty;
  logic [1:0] l_act, r_act, nl_in, nr_in, f, r;
  logic [3:0] n_cmd;
  logic same, wrap, rev, load, run_n;
  always_comb begin
    f = pend[0] ? 2'b10 : 2'b01;
    r = ~f;
    n_cmd = pend[4:1];
    nl_duty = CNT_W'(DUTY_FULL);
    nr_duty = CNT_W'(DUTY_FULL);
    nl_in = f;
    nr_in = f;
    case (pend[4:1])
      4'b0000: ;
      4'b1001: nr_duty = CNT_W'(DUTY_VEER);
      4'b0101: nl_duty = CNT_W'(DUTY_VEER);
      4'b1010: nr_duty = CNT_W'(DUTY_HARD);
      4'b0110: nl_duty = CNT_W'(DUTY_HARD);
      4'b1011: begin
        nl_duty = CNT_W'(DUTY_PIVOT);
        nr_duty = CNT_W'(DUTY_PIVOT);
        nr_in = r;
      end
      4'b0111: begin
        nl_duty = CNT_W'(DUTY_PIVOT);
        nr_duty = CNT_W'(DUTY_PIVOT);
        nl_in = r;
      end
      default: begin
        n_cmd = 4'b1111;
        nl_duty = '0;
        nr_duty = '0;
        nl_in = 2'b11;
        nr_in = 2'b11;
      end
    endcase
  end
  // active and decoded inputs are never 00, so xor==11 only flags a 10<->01 swap
  assign rev   = ((l_act ^ nl_in) == 2'b11) || ((r_act ^ nr_in) == 2'b11);
  assign same  = {DIR, Direction} == samp;
  assign wrap  = cnt == CNT_W'(PWM_PERIOD - 1);
  assign cnt_n = wrap ? '0 : cnt + 1'b1;
  // after dead-time the bridge has coasted, so any polarity loads directly
  assign load  = wrap && (state == WAIT_WRAP || (state == RUN && !rev));
  assign run_n = load || (state == RUN && !(wrap && rev));
  assign ld_n  = load ? nl_duty : l_duty;
  assign rd_n  = load ? nr_duty : r_duty;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      samp <= 5'b11111;
      pend <= 5'b11111;
      hcnt <= '0;
      dcnt <= '0;
      cnt <= '0;
      l_duty <= '0;
      r_duty <= '0;
      l_act <= 2'b11;
      r_act <= 2'b11;
      L_IN <= 2'b00;
      R_IN <= 2'b00;
      L_PWM <= 1'b0;
      R_PWM <= 1'b0;
      CMD <= 4'b1111;
      DEAD <= 1'b0;
    end else begin
      samp <= {DIR, Direction};
      hcnt <= !same ? '0 : (hcnt == HW'(CMD_HOLD) ? hcnt : hcnt + 1'b1);
      pend <= (same && hcnt >= HW'(CMD_HOLD - 1)) ? samp : pend;
      cnt <= cnt_n;
      l_duty <= ld_n;
      r_duty <= rd_n;
      L_PWM <= run_n && (cnt_n < ld_n);
      R_PWM <= run_n && (cnt_n < rd_n);
      case (state)
        RUN: if (wrap && rev) begin
          state <= DEADT;
          dcnt <= '0;
          DEAD <= 1'b1;
          L_IN <= 2'b00;
          R_IN <= 2'b00;
        end
        DEADT: begin
          dcnt <= dcnt + 1'b1;
          state <= dcnt == DW'(DEADTIME - 1) ? WAIT_WRAP : DEADT;
        end
        default: ;
      endcase
      if (load) begin
        state <= RUN;
        DEAD <= 1'b0;
        l_act <= nl_in;
        r_act <= nr_in;
        L_IN <= nl_in;
        R_IN <= nr_in;
        CMD <= n_cmd;
      end
    end
  end
endmodule

// File: tb/tb_motor_drive_decoder.sv
// tb_motor_drive_decoder: directed and random steering steps checked against a table-level model of the decoder
module tb_motor_drive_decoder;
  localparam int PERIOD = 1000, FULL = 900, VEER = 600, HARD = 300, PIVOT = 700;
  localparam int HOLD = 16, DT = 500;
  logic clk = 1'b0, rst = 1'b1, Direction = 1'b1;
  logic [3:0] DIR = 4'b0000;
  logic L_PWM, R_PWM, DEAD;
  logic [1:0] L_IN, R_IN;
  logic [3:0] CMD;
  int n_chk = 0, n_fail = 0;
  logic [3:0] cur_cmd = 4'b1111;
  logic [1:0] cur_li = 2'b11, cur_ri = 2'b11;
  always #5 clk = ~clk;
  motor_drive_decoder dut (
    .clk(clk), .rst(rst), .DIR(DIR), .Direction(Direction),
    .L_PWM(L_PWM), .R_PWM(R_PWM), .L_IN(L_IN), .R_IN(R_IN), .CMD(CMD), .DEAD(DEAD)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // side picks which motor is inner; level picks veer/hard/pivot; pivot reverses the inner motor
  task automatic model(input logic [3:0] c, input logic d, output logic [3:0] cmd,
                       output int ld, output int rd, output logic [1:0] li, output logic [1:0] ri);
    logic [1:0] side, lvl, fw, bw;
    int inner, outer;
    side = c[3:2];
    lvl = c[1:0];
    fw = d ? 2'b10 : 2'b01;
    bw = d ? 2'b01 : 2'b10;
    if (c == 4'b0000) begin
      cmd = c; ld = FULL; rd = FULL; li = fw; ri = fw;
    end else if ((side == 2'b10 || side == 2'b01) && lvl != 2'b00) begin
      cmd = c;
      inner = lvl == 2'd1 ? VEER : lvl == 2'd2 ? HARD : PIVOT;
      outer = lvl == 2'd3 ? PIVOT : FULL;
      if (side == 2'b10) begin
        ld = outer; rd = inner; li = fw; ri = lvl == 2'd3 ? bw : fw;
      end else begin
        ld = inner; rd = outer; li = lvl == 2'd3 ? bw : fw; ri = fw;
      end
    end else begin
      cmd = 4'b1111; ld = 0; rd = 0; li = 2'b11; ri = 2'b11;
    end
  endtask
  function automatic bit flips(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'b10 && b == 2'b01) || (a == 2'b01 && b == 2'b10);
  endfunction
  task automatic step(input string tag, input logic [3:0] c, input logic d);
    logic [3:0] e_cmd;
    logic [1:0] e_li, e_ri;
    int e_ld, e_rd, dead_len, bad_dead, l_hi, r_hi, errs;
    bit rev, ok, seen;
    model(c, d, e_cmd, e_ld, e_rd, e_li, e_ri);
    rev = flips(cur_li, e_li) || flips(cur_ri, e_ri);
    DIR = c;
    Direction = d;
    dead_len = 0; bad_dead = 0; ok = 0; seen = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (DEAD) begin
        seen = 1;
        dead_len++;
        if (L_IN != 2'b00 || R_IN != 2'b00 || L_PWM || R_PWM) bad_dead++;
      end
      if (CMD == e_cmd && L_IN == e_li && R_IN == e_ri && !DEAD) ok = 1;
    end
    check({tag, "_reached"}, ok, 1);
    check({tag, "_dead_seen"}, seen, rev);
    check({tag, "_dead_long"}, dead_len >= DT, rev);
    check({tag, "_dead_outputs_off"}, bad_dead, 0);
    l_hi = 0; r_hi = 0; errs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      l_hi += int'(L_PWM);
      r_hi += int'(R_PWM);
      if (L_PWM !== (i < e_ld) || R_PWM !== (i < e_rd)) errs++;
      if (CMD != e_cmd || L_IN != e_li || R_IN != e_ri || DEAD) errs++;
    end
    check({tag, "_l_duty"}, l_hi, e_ld);
    check({tag, "_r_duty"}, r_hi, e_rd);
    check({tag, "_period_shape"}, errs, 0);
    cur_cmd = e_cmd; cur_li = e_li; cur_ri = e_ri;
  endtask
  initial begin
    logic [3:0] c, m_cmd;
    logic d;
    logic [1:0] m_li, m_ri;
    int m_ld, m_rd, bad;
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_l_pwm", L_PWM, 0);
    check("rst_r_pwm", R_PWM, 0);
    check("rst_in", {L_IN, R_IN}, 4'b0000);
    check("rst_cmd", CMD, 4'b1111);
    check("rst_dead", DEAD, 0);
    rst = 1'b0;
    step("proceed", 4'b0000, 1'b1);
    DIR = 4'b1010;
    repeat (10) @(negedge clk);
    DIR = 4'b0000;
    bad = 0;
    repeat (2200) begin
      @(negedge clk);
      if (CMD != 4'b0000 || L_IN != 2'b10 || R_IN != 2'b10 || DEAD) bad++;
    end
    check("glitch_ignored", bad, 0);
    step("veer_right", 4'b1001, 1'b1);
    step("ninety_right", 4'b1011, 1'b1);
    step("proceed_back", 4'b0000, 1'b1);
    step("reverse_travel", 4'b0000, 1'b0);
    step("stop", 4'b1111, 1'b0);
    step("proceed_rev", 4'b0000, 1'b0);
    step("invalid_0011", 4'b0011, 1'b0);
    for (int k = 0; k < 7; k++) begin
      do begin
        c = 4'($urandom_range(0, 15));
        d = 1'($urandom_range(0, 1));
        model(c, d, m_cmd, m_ld, m_rd, m_li, m_ri);
      end while (m_cmd == cur_cmd && m_li == cur_li && m_ri == cur_ri);
      step($sformatf("rand%0d", k), c, d);
    end
    step("pre_reset", 4'b0111, 1'b1);
    DIR = 4'b0111;
    Direction = 1'b0;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = DEAD;
    end
    check("deadtime_entered", seen, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", {L_PWM, R_PWM}, 2'b00);
    check("async_rst_in", {L_IN, R_IN}, 4'b0000);
    check("async_rst_cmd", CMD, 4'b1111);
    check("async_rst_dead", DEAD, 0);
    @(negedge clk);
    rst = 1'b0;
    cur_cmd = 4'b1111; cur_li = 2'b11; cur_ri = 2'b11;
    step("after_reset", 4'b0101, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
